// File: rtl/muldiv_sequencer.sv
// Sequences the multi-cycle mult/div units: runs the selected enable for a
// fixed cycle count, then strobes HI/LO write with a done/busy handshake.
module muldiv_sequencer #(
  parameter int unsigned MULT_CYCLES = 33,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic        abort,
  input  logic [31:0] b_operand,
  output logic        MultCtrl,
  output logic        DivCtrl,
  output logic        HISrc,
  output logic        LOSrc,
  output logic        HILOWrite,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    WRITE    = 3'd3,
    ZERO     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               hisrc_q, hisrc_d;
  logic               mult_ctrl_q, mult_ctrl_d;
  logic               div_ctrl_q, div_ctrl_d;
  logic               hilo_write_q, hilo_write_d;
  logic               busy_q, busy_d;
  logic               div_zero_q, div_zero_d;

  // Next-state logic; outputs are decoded from the next state so they flop
  // alongside it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hisrc_d  = hisrc_q;

    unique case (state_q)
      IDLE: begin
        if (!abort) begin
          if (mult_req) begin
            state_d  = MULT_RUN;
            cnt_d    = CNT_W'(MULT_CYCLES - 1);
            is_div_d = 1'b0;
          end else if (div_req) begin
            if (b_operand == 32'd0) begin
              state_d = ZERO;
            end else begin
              state_d  = DIV_RUN;
              cnt_d    = CNT_W'(DIV_CYCLES - 1);
              is_div_d = 1'b1;
            end
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE, ZERO: state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    if (state_d == WRITE) begin
      hisrc_d = is_div_q;
    end

    mult_ctrl_d  = (state_d == MULT_RUN);
    div_ctrl_d   = (state_d == DIV_RUN);
    hilo_write_d = (state_d == WRITE);
    div_zero_d   = (state_d == ZERO);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_div_q     <= 1'b0;
      hisrc_q      <= 1'b0;
      mult_ctrl_q  <= 1'b0;
      div_ctrl_q   <= 1'b0;
      hilo_write_q <= 1'b0;
      busy_q       <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_div_q     <= is_div_d;
      hisrc_q      <= hisrc_d;
      mult_ctrl_q  <= mult_ctrl_d;
      div_ctrl_q   <= div_ctrl_d;
      hilo_write_q <= hilo_write_d;
      busy_q       <= busy_d;
      div_zero_q   <= div_zero_d;
    end
  end

  assign MultCtrl  = mult_ctrl_q;
  assign DivCtrl   = div_ctrl_q;
  assign HISrc     = hisrc_q;
  assign LOSrc     = hisrc_q;
  assign HILOWrite = hilo_write_q;
  assign done      = hilo_write_q;
  assign busy      = busy_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a queue of expected per-cycle
// output vectors is scheduled whenever the model accepts a request.
module tb_muldiv_sequencer;

  localparam int unsigned N_MULT = 33;
  localparam int unsigned N_DIV  = 33;

  // Vector bits: {MultCtrl, DivCtrl, HILOWrite, done, busy, div_zero, HISrc, LOSrc}
  localparam logic [7:0] V_RUN_M = 8'b1000_1000;
  localparam logic [7:0] V_RUN_D = 8'b0100_1000;
  localparam logic [7:0] V_WR_M  = 8'b0011_1000;
  localparam logic [7:0] V_WR_D  = 8'b0011_1011;
  localparam logic [7:0] V_ZERO  = 8'b0000_1100;

  logic        clk;
  logic        reset;
  logic        mult_req, div_req, abort;
  logic [31:0] b_operand;
  logic        MultCtrl, DivCtrl, HISrc, LOSrc, HILOWrite, busy, done, div_zero;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic       active_m;
  logic       src_m;
  logic [7:0] exp_v, act_v;

  muldiv_sequencer #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mult_req(mult_req), .div_req(div_req),
    .abort(abort), .b_operand(b_operand), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
    .HISrc(HISrc), .LOSrc(LOSrc), .HILOWrite(HILOWrite), .busy(busy),
    .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sample();
    return {MultCtrl, DivCtrl, HILOWrite, done, busy, div_zero, HISrc, LOSrc};
  endfunction

  task automatic model_reset();
    q.delete();
    active_m = 1'b0;
    src_m    = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample after it.
  task automatic step(input logic m, input logic d, input logic a, input logic [31:0] b);
    logic [7:0] v;
    mult_req  = m;
    div_req   = d;
    abort     = a;
    b_operand = b;
    @(posedge clk);
    if (!active_m) begin
      if (!a) begin
        if (m) begin
          for (int i = 0; i < N_MULT; i++) q.push_back(V_RUN_M);
          q.push_back(V_WR_M);
        end else if (d) begin
          if (b == 32'd0) q.push_back(V_ZERO);
          else begin
            for (int i = 0; i < N_DIV; i++) q.push_back(V_RUN_D);
            q.push_back(V_WR_D);
          end
        end
      end
    end else if (a) begin
      q.delete();
    end
    v = (q.size() > 0) ? q.pop_front() : 8'h00;
    if (v[5]) src_m = v[0];
    exp_v    = {v[7:2], src_m, src_m};
    active_m = v[3];
    #1;
    act_v = sample();
  endtask

  task automatic idle_steps(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      total++;
      if (act_v !== exp_v) $display("FAIL %s cyc%0d: got %b want %b", name, i, act_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mult_req = 1'b0; div_req = 1'b0; abort = 1'b0; b_operand = 32'd0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (sample() !== 8'h00) $display("FAIL reset_outputs: got %b want 00000000", sample());
    else passed++;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    idle_steps(10, "reset_idle");
  endtask

  task automatic test_mult();
    int n_mult = 0, n_busy = 0, n_wr = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_mult += int'(MultCtrl); n_busy += int'(busy); n_wr += int'(HILOWrite);
      total++;
      if (act_v !== exp_v) $display("FAIL mult cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
    total++;
    if (n_mult != N_MULT) $display("FAIL mult_len: got %0d want %0d", n_mult, N_MULT); else passed++;
    total++;
    if (n_busy != N_MULT + 1) $display("FAIL mult_busy: got %0d want %0d", n_busy, N_MULT + 1); else passed++;
    total++;
    if (n_wr != 1) $display("FAIL mult_write: got %0d want 1", n_wr); else passed++;
  endtask

  task automatic test_div();
    int n_div = 0, n_wr = 0;
    step(1'b0, 1'b1, 1'b0, 32'h0000_0007);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_div += int'(DivCtrl); n_wr += int'(HILOWrite);
      total++;
      if (act_v !== exp_v) $display("FAIL div cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
    total++;
    if (n_div != N_DIV) $display("FAIL div_len: got %0d want %0d", n_div, N_DIV); else passed++;
    total++;
    if (n_wr != 1 || HISrc !== 1'b1 || LOSrc !== 1'b1)
      $display("FAIL div_write: got wr=%0d src=%b%b want wr=1 src=11", n_wr, HISrc, LOSrc);
    else passed++;
  endtask

  task automatic test_div_zero();
    int n_dz = 0, n_bad = 0;
    step(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_dz += int'(div_zero); n_bad += int'(DivCtrl) + int'(HILOWrite) + int'(done);
      total++;
      if (act_v !== exp_v) $display("FAIL div_zero cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
    total++;
    if (n_dz != 1 || n_bad != 0) $display("FAIL div_zero_pulse: got dz=%0d other=%0d want dz=1 other=0", n_dz, n_bad);
    else passed++;
  endtask

  task automatic test_collision();
    int n_div = 0, n_wr = 0;
    step(1'b1, 1'b1, 1'b0, 32'd7);
    for (int i = 0; i < 40; i++) begin
      if (i == 9) step(1'b0, 1'b1, 1'b0, 32'd9);
      else if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_div += int'(DivCtrl); n_wr += int'(HILOWrite);
      total++;
      if (act_v !== exp_v) $display("FAIL collision cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
    total++;
    if (n_div != 0 || n_wr != 1 || HISrc !== 1'b0)
      $display("FAIL collision_result: got div=%0d wr=%0d src=%b want 0 1 0", n_div, n_wr, HISrc);
    else passed++;
  endtask

  task automatic test_abort();
    int n_wr = 0;
    step(1'b0, 1'b1, 1'b0, 32'd5);
    for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    total++;
    if (act_v !== exp_v || DivCtrl !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_div: got %b want %b", act_v, exp_v);
    else passed++;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      n_wr += int'(HILOWrite);
      total++;
      if (act_v !== exp_v) $display("FAIL abort_then_mult cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
    total++;
    if (n_wr != 1) $display("FAIL abort_then_mult_write: got %0d want 1", n_wr); else passed++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (sample() !== 8'h00) $display("FAIL async_reset: got %b want 00000000", sample());
    else passed++;
    @(posedge clk);
    #3 reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 38; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 32'd0);
      total++;
      if (act_v !== exp_v) $display("FAIL post_reset_mult cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    while (!done && guard < 100) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      guard++;
    end
    total++;
    if (guard >= 100) $display("FAIL b2b_timeout: got no done want done");
    else passed++;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd3);
    total++;
    if (act_v !== exp_v || DivCtrl !== 1'b1)
      $display("FAIL b2b_accept: got %b want %b", act_v, exp_v);
    else passed++;
    idle_steps(36, "b2b_div");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic m, d, a;
      logic [31:0] b;
      m = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(m, d, a, b);
      total++;
      if (act_v !== exp_v) $display("FAIL random cyc%0d: got %b want %b", i, act_v, exp_v);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_collision();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
